// File: rtl/cordic_bus_pkg.sv
// Shared definitions for the CORDIC bus endpoint: FSM encoding,
// operand field offsets within the packed input word, and the result
// word reported when a job is aborted.
package cordic_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int          X_LSB        = 16;
    localparam int          Y_LSB        = 0;
    localparam logic [31:0] TIMEOUT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/cordic_core_endpoint_if.sv
// Adapter-side bundle of the CORDIC endpoint: operand strobe, result pop,
// FIFO head and status flags. The adapter is the master, the endpoint the slave.
interface cordic_core_endpoint_if;

    logic [31:0] in_interface;
    logic        valid_in_interface;
    logic        rd_interface;
    logic [31:0] out_interface;
    logic        valid_out_interface;
    logic        empty;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    modport master (
        output in_interface, valid_in_interface, rd_interface,
        input  out_interface, valid_out_interface, empty, busy, overflow, timeout_err
    );

    modport slave (
        input  in_interface, valid_in_interface, rd_interface,
        output out_interface, valid_out_interface, empty, busy, overflow, timeout_err
    );

endinterface

// File: rtl/cordic_result_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on data_o.
// Push while full and pop while empty are ignored; count, empty and full are registered.
module cordic_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q;
    logic             push_eff, pop_eff;

    // Qualify requests against occupancy and derive the next count.
    always_comb begin
        push_eff = push_i && !full_q;
        pop_eff  = pop_i && (count_q != '0);
        count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
    end

    // Storage, pointers and registered occupancy flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push_eff) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/cordic_core_endpoint.sv
// CORDIC-side responder: holds one operand command, sequences a single core
// job through start/done with a cycle timeout, and queues packed results.
module cordic_core_endpoint
    import cordic_bus_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    cordic_core_endpoint_if.slave   bus,
    output logic                    core_start,
    output logic [INPUT_WIDTH-1:0]  core_x,
    output logic [INPUT_WIDTH-1:0]  core_y,
    input  logic                    core_done,
    input  logic [OUTPUT_WIDTH-1:0] core_res_a,
    input  logic [OUTPUT_WIDTH-1:0] core_res_b
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic                   cmd_full_q, cmd_full_d;
    logic [INPUT_WIDTH-1:0] cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
    logic [INPUT_WIDTH-1:0] core_x_q, core_x_d, core_y_q, core_y_d;
    logic                   core_start_q, core_start_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   overflow_q, overflow_d;
    logic                   timeout_q, timeout_d;
    logic                   valid_out_q;

    logic                   push_req, push;
    logic [31:0]            push_data;
    logic [15:0]            res_a_ext, res_b_ext;
    logic [31:0]            fifo_head;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty, fifo_full;

    assign res_a_ext = 16'(signed'(core_res_a));
    assign res_b_ext = 16'(signed'(core_res_b));

    // Next-state logic: FSM transitions, timer, then command register.
    // The FSM runs first so a strobe in the consume cycle sees the freed register.
    always_comb begin
        state_d      = state_q;
        cmd_full_d   = cmd_full_q;
        cmd_x_d      = cmd_x_q;
        cmd_y_d      = cmd_y_q;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        core_start_d = 1'b0;
        timer_d      = timer_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        push_req     = 1'b0;
        push_data    = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_full_q && (fifo_count < CW'(FIFO_DEPTH))) begin
                    state_d      = S_ISSUE;
                    core_x_d     = cmd_x_q;
                    core_y_d     = cmd_y_q;
                    cmd_full_d   = 1'b0;
                    core_start_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (core_done) begin
                    push_req  = 1'b1;
                    push_data = {res_a_ext, res_b_ext};
                    state_d   = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    push_req  = 1'b1;
                    push_data = TIMEOUT_WORD;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.valid_in_interface) begin
            if (!cmd_full_d) begin
                cmd_x_d    = bus.in_interface[X_LSB +: INPUT_WIDTH];
                cmd_y_d    = bus.in_interface[Y_LSB +: INPUT_WIDTH];
                cmd_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    assign push = push_req && !fifo_full;

    // State and datapath registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            cmd_full_q   <= 1'b0;
            cmd_x_q      <= '0;
            cmd_y_q      <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            core_start_q <= 1'b0;
            timer_q      <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_full_q   <= cmd_full_d;
            cmd_x_q      <= cmd_x_d;
            cmd_y_q      <= cmd_y_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            core_start_q <= core_start_d;
            timer_q      <= timer_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            valid_out_q  <= push;
        end
    end

    cordic_result_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (bus.rd_interface),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.out_interface       = fifo_head;
    assign bus.valid_out_interface = valid_out_q;
    assign bus.empty               = fifo_empty;
    assign bus.busy                = cmd_full_q || (state_q != S_IDLE);
    assign bus.overflow            = overflow_q;
    assign bus.timeout_err         = timeout_q;
    assign core_start              = core_start_q;
    assign core_x                  = core_x_q;
    assign core_y                  = core_y_q;

endmodule
